// File: rtl/mem_delay_bank.sv
// mem_delay_bank: a bank of independent spike-delay channels aligned to a gamma cycle.
// A grst strobe opens a gamma cycle. It clears the shared gamma counter and latches the
// per-channel delays. During the cycle, each channel turns its first rising input edge
// into a PULSE_WIDTH-cycle output pulse, delayed by dly cycles. If that pulse could not
// start inside the gamma cycle, the channel raises a sticky dropped flag and emits nothing.
//
// Channel FSM
//   state | meaning
//   IDLE  | armed, waiting for the first rising edge of this gamma cycle
//   WAIT  | edge accepted, counting down the programmed delay
//   FIRE  | driving the output pulse, counting down the pulse length
//   DONE  | fired or dropped this gamma cycle (also the post-reset state)
module mem_delay_bank #(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                                        aclk,
  input  logic                                        rst_n,
  input  logic                                        grst,
  input  logic [N_CH-1:0]                             in,
  input  logic [N_CH*$clog2(GAMMA_CYCLE_WIDTH)-1:0]   delay,
  output logic [N_CH-1:0]                             out,
  output logic [N_CH-1:0]                             dropped
);

  localparam int DW  = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  // One counter per channel serves both the delay and the pulse countdown.
  localparam int CW  = (PCW > DW) ? PCW : DW;
  localparam logic [DW-1:0] GCNT_MAX = DW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [DW:0]   LAST     = (DW+1)'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_DONE} state_t;

  logic [DW-1:0]            gcnt;
  logic [N_CH-1:0][DW-1:0]  dly;
  logic [N_CH-1:0]          prev;

  // Gamma counter: cleared by grst, otherwise counts up and sticks at the last cycle.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
    end else if (grst) begin
      gcnt <= '0;
    end else if (gcnt != GCNT_MAX) begin
      gcnt <= gcnt + DW'(1);
    end
  end

  // Delay fields are captured only at gamma start and held for the whole cycle.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= '0;
    end else if (grst) begin
      dly <= delay;
    end
  end

  // Previous-input register for edge detection. It tracks through grst, so an input
  // held high across the strobe is not seen as a new edge.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
    end else begin
      prev <= in;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          out_q;
    logic          drop_q;
    logic          rise;
    logic [DW:0]   sum;

    assign rise = in[i] & ~prev[i];
    // Last pulse start cycle measured from the sampling cycle; one extra bit so it cannot overflow.
    assign sum  = {1'b0, gcnt} + {1'b0, dly[i]} + (DW+1)'(1);

    // Per-channel sequencer. grst overrides everything and re-arms the channel.
    always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= S_DONE;
        cnt    <= '0;
        out_q  <= 1'b0;
        drop_q <= 1'b0;
      end else if (grst) begin
        state  <= S_IDLE;
        cnt    <= '0;
        out_q  <= 1'b0;
        drop_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) begin
              if (sum > LAST) begin
                state  <= S_DONE;
                drop_q <= 1'b1;
              end else if (dly[i] == '0) begin
                state <= S_FIRE;
                out_q <= 1'b1;
                cnt   <= CW'(PULSE_WIDTH - 1);
              end else begin
                state <= S_WAIT;
                cnt   <= CW'(dly[i]) - CW'(1);
              end
            end
          end
          S_WAIT: begin
            if (cnt == '0) begin
              state <= S_FIRE;
              out_q <= 1'b1;
              cnt   <= CW'(PULSE_WIDTH - 1);
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_FIRE: begin
            if (cnt == '0) begin
              state <= S_DONE;
              out_q <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_DONE: begin
            state <= S_DONE;
          end
          default: begin
            state <= S_DONE;
            out_q <= 1'b0;
          end
        endcase
      end
    end

    assign out[i]     = out_q;
    assign dropped[i] = drop_q;
  end

endmodule

// File: tb/tb_mem_delay_bank.sv
// Bench for mem_delay_bank (N_CH=4, GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=2).
// Each table row is one clock cycle of stimulus. Its expected outputs are the values
// seen in the following cycle.
module tb_mem_delay_bank;

  logic        aclk;
  logic        rst_n;
  logic        grst;
  logic [3:0]  in_v;
  logic [15:0] delay;
  logic [3:0]  out;
  logic [3:0]  dropped;

  int n_vec = 0;
  int n_err = 0;

  mem_delay_bank #(
    .N_CH(4),
    .GAMMA_CYCLE_WIDTH(16),
    .PULSE_WIDTH(2)
  ) dut (
    .aclk(aclk),
    .rst_n(rst_n),
    .grst(grst),
    .in(in_v),
    .delay(delay),
    .out(out),
    .dropped(dropped)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        grst;
    logic [3:0]  in_v;
    logic [15:0] delay;
    logic [3:0]  exp_out;
    logic [3:0]  exp_drop;
  } vec_t;

  typedef struct {
    logic [3:0] out;
    logic [3:0] drop;
    string      tag;
  } exp_t;

  localparam int NV = 56;
  // ch3=1, ch2=5, ch1=0, ch0=3
  localparam logic [15:0] DLY_A = 16'h1503;

  vec_t vecs[NV];
  exp_t sb_q[$];

  task automatic check_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      n_vec++;
      if (out !== e.out || dropped !== e.drop) begin
        n_err++;
        $display("FAIL %s: got out=%b dropped=%b, want out=%b dropped=%b",
                 e.tag, out, dropped, e.out, e.drop);
      end
    end
  endtask

  task automatic push_exp(input logic [3:0] eo, input logic [3:0] ed, input string tag);
    exp_t e;
    e.out  = eo;
    e.drop = ed;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus (called #1 after a rising edge), then check the outputs it produced.
  task automatic apply(input logic g, input logic [3:0] iv, input logic [15:0] d,
                       input logic [3:0] eo, input logic [3:0] ed, input string tag);
    grst  = g;
    in_v  = iv;
    delay = d;
    push_exp(eo, ed, tag);
    @(posedge aclk);
    #1;
    check_head();
  endtask

  task automatic check_now(input logic [3:0] eo, input logic [3:0] ed, input string tag);
    push_exp(eo, ed, tag);
    check_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Default row: idle, with garbage on the delay port to prove it is ignored outside grst.
    for (int k = 0; k < NV; k++) vecs[k] = '{1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000};

    // Gamma 1: row c means gcnt = c-1.
    vecs[0]  = '{1'b1, 4'b0000, DLY_A, 4'b0000, 4'b0000};
    vecs[3]  = '{1'b0, 4'b0001, 16'hFFFF, 4'b0000, 4'b0000}; // ch0 edge gcnt=2
    vecs[5]  = '{1'b0, 4'b0010, 16'hFFFF, 4'b0010, 4'b0000}; // ch1 edge gcnt=4, dly 0
    vecs[6]  = '{1'b0, 4'b0000, 16'hFFFF, 4'b0011, 4'b0000}; // gcnt=6: ch0 on, ch1 2nd
    vecs[7]  = '{1'b0, 4'b0000, 16'hFFFF, 4'b0001, 4'b0000}; // gcnt=7: ch0 2nd
    vecs[10] = '{1'b0, 4'b0010, 16'hFFFF, 4'b0000, 4'b0000}; // ch1 second rise ignored
    vecs[12] = '{1'b0, 4'b0100, 16'hFFFF, 4'b0000, 4'b0100}; // ch2 gcnt=11 -> drop
    for (int k = 13; k <= 18; k++) vecs[k].exp_drop = 4'b0100;
    vecs[14] = '{1'b0, 4'b1000, 16'hFFFF, 4'b0000, 4'b0100}; // ch3 edge gcnt=13
    vecs[15].exp_out = 4'b1000;                               // gcnt=15
    vecs[16].exp_out = 4'b1000;                               // saturated, 2nd cycle
    vecs[19] = '{1'b1, 4'b0000, DLY_A, 4'b0000, 4'b0000};     // dropped clears
    // Gamma 2: row c means gcnt = c-20. ch3 edge at gcnt 13, grst in the second pulse cycle.
    for (int k = 33; k <= 45; k++) vecs[k].in_v = 4'b1000;
    vecs[34].exp_out = 4'b1000;
    vecs[35].exp_out = 4'b1000;
    vecs[36] = '{1'b1, 4'b1000, DLY_A, 4'b0000, 4'b0000};     // cut, held input
    // Gamma 3: all channels with zero delay, simultaneous edges.
    vecs[47] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000};
    vecs[48] = '{1'b0, 4'b1111, 16'hFFFF, 4'b1111, 4'b0000};
    vecs[49] = '{1'b0, 4'b1111, 16'hFFFF, 4'b1111, 4'b0000};
    // grst coincident with edges: edges discarded, held inputs give no new edge.
    vecs[52] = '{1'b1, 4'b1111, 16'h0000, 4'b0000, 4'b0000};
    for (int k = 53; k <= 55; k++) vecs[k].in_v = 4'b1111;

    rst_n = 1'b0;
    grst  = 1'b0;
    in_v  = 4'b0000;
    delay = 16'h0000;
    #12;
    check_now(4'b0000, 4'b0000, "reset_state");
    @(posedge aclk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++)
      apply(vecs[k].grst, vecs[k].in_v, vecs[k].delay,
            vecs[k].exp_out, vecs[k].exp_drop, $sformatf("vec%0d", k));

    // Asynchronous reset in the middle of a pulse.
    apply(1'b1, 4'b0000, 16'h0003, 4'b0000, 4'b0000, "rst_setup");
    apply(1'b0, 4'b0001, 16'hFFFF, 4'b0000, 4'b0000, "rst_edge");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000, "rst_wait1");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000, "rst_wait2");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0001, 4'b0000, "rst_pulse_on");
    #2;
    rst_n = 1'b0;
    #1;
    check_now(4'b0000, 4'b0000, "rst_async_clear");
    repeat (2) @(posedge aclk);
    #1;
    check_now(4'b0000, 4'b0000, "rst_held");
    rst_n = 1'b1;

    // No firing after reset until a grst.
    apply(1'b0, 4'b0001, 16'h0000, 4'b0000, 4'b0000, "nogrst_edge");
    for (int k = 0; k < 6; k++)
      apply(1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, $sformatf("nogrst_idle%0d", k));

    // Operation resumes after grst.
    apply(1'b1, 4'b0000, 16'h0003, 4'b0000, 4'b0000, "regrst");
    apply(1'b0, 4'b0001, 16'hFFFF, 4'b0000, 4'b0000, "regrst_edge");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000, "regrst_wait1");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000, "regrst_wait2");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0001, 4'b0000, "regrst_pulse1");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0001, 4'b0000, "regrst_pulse2");
    apply(1'b0, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000, "regrst_end");

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries left, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_delay_bank.md
MEM_DELAY_BANK -- requirements
Module: mem_delay_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent delay channels, at least 1.
REQ-002 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: cycles per gamma cycle, a power of 2 and at least 2.
REQ-003 SHALL have parameter PULSE_WIDTH, default 8: output pulse length in cycles, at least 1.
REQ-004 SHALL use DW = $clog2(GAMMA_CYCLE_WIDTH) as the width of each delay field and of the gamma counter.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port grst, input, 1 bit: synchronous gamma-start strobe, sampled on aclk.
REQ-008 SHALL have port in, input, N_CH bits: spike input; channel i is in[i].
REQ-009 SHALL have port delay, input, N_CH*DW bits: per-channel delay; channel i is delay[i*DW +: DW].
REQ-010 SHALL have port out, output, N_CH bits: registered delayed spike pulses.
REQ-011 SHALL have port dropped, output, N_CH bits: sticky per-gamma flag, set when a channel's spike would fall outside the gamma cycle.

Function
REQ-012 SHALL keep one gamma counter gcnt.
- grst: next gcnt = 0.
- Otherwise: gcnt increments by 1 and saturates at GAMMA_CYCLE_WIDTH-1; it never wraps.
REQ-013 SHALL latch each channel's delay field into a per-channel register dly[i] in any cycle where grst=1.
- dly[i] holds constant for the rest of the gamma cycle.
- Changes on the delay port outside grst cycles have no effect.
REQ-014 SHALL keep a per-channel previous-input register prev[i].
- prev[i] updates to in[i] every cycle, grst cycles included.
- A rising edge is in[i]=1 with prev[i]=0.
- An input held high across a grst does not count as a new edge.
REQ-015 SHALL run one FSM per channel with states IDLE, WAIT, FIRE, DONE.
REQ-016 In IDLE, on a rising edge sampled while gcnt=g, the channel SHALL check g+dly+1 against GAMMA_CYCLE_WIDTH-1, computed at DW+1 bits:
- g+dly+1 > GAMMA_CYCLE_WIDTH-1: go to DONE, set dropped[i], emit no pulse.
- dly=0: go to FIRE.
- otherwise: go to WAIT.
REQ-017 For an accepted edge sampled at cycle t, out[i] SHALL be high exactly in cycles t+dly+1 through t+dly+PULSE_WIDTH, unless cut short by grst or reset.
- The channel is in FIRE during those cycles.
- After the last pulse cycle the channel goes to DONE.
REQ-018 Edges arriving in WAIT, FIRE or DONE SHALL be ignored; each channel fires at most once per gamma cycle.
REQ-019 A pulse that runs past gcnt saturation SHALL continue until PULSE_WIDTH cycles are done or a grst occurs.
REQ-020 grst SHALL take priority over every other event.
- Next cycle: all FSMs are in IDLE, out = 0 and dropped = 0.
- An edge sampled in the grst cycle is discarded.
- A pulse in progress is cut off: out falls in the cycle after grst.
REQ-021 Channels SHALL be fully independent except for sharing gcnt and grst; simultaneous edges on several channels are each handled per REQ-016 and REQ-017.
REQ-022 out and dropped SHALL be driven directly from flops, with no combinational path from in, delay or grst.

Reset
REQ-023 While rst_n=0, the following SHALL be 0 immediately (asynchronously) and held there: gcnt, every dly[i], every prev[i], out, dropped, and all pulse/delay counters; every FSM SHALL be in DONE.
REQ-024 After rst_n deasserts, no channel SHALL fire until the first grst; a grst is required to start operation.
REQ-025 Reset asserted mid-pulse or mid-wait SHALL drop out to 0 in the same instant, with no pulse after release.

Verification (N_CH=4, GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=2)
REQ-026 Setup: grst with delay={3,0,5,1}; then in[0] rises at gcnt=2 -> out[0] high while gcnt=6 and 7; dropped=0.
REQ-027 Zero delay: dly[1]=0, in[1] rises at gcnt=4 -> out[1] high at gcnt=5,6; a second rise at gcnt=9 produces no pulse.
REQ-028 Drop: dly[2]=5, in[2] rises at gcnt=11 (11+5+1=17 > 15) -> no pulse; dropped[2]=1 until the next grst, then 0.
REQ-029 Cut and hold: dly[3]=1, in[3] rises at gcnt=13 -> out[3] high at gcnt=15, stays high one more cycle with gcnt saturated at 15. Repeat with grst in the second pulse cycle -> out[3]=0 the cycle after grst; in[3] held high through grst -> no new pulse.
REQ-030 Reset: assert rst_n=0 while out[0] is high -> out=0 immediately. Release rst_n, pulse in[0] -> no output until a grst has been applied.
REQ-031 Simultaneous events: all four channels rise at gcnt=0 with delay={0,0,0,0} -> out=4'b1111 at gcnt=1,2. Apply grst and an edge in the same cycle -> the edge is ignored.
